prbs_tx_seq: RTL and testbench
==============================

# prbs_tx_seq

Run sequencer for the 1280 MHz PRBS transmit path. It sits between the PRBS word generator and the serializer lane. On a start request it reseeds the generator and sends a fixed idle/comma preamble so the far-end checker can align. It then streams a counted burst of 16-bit PRBS words, or streams continuously, and returns the lane to idle. With the optional feature compiled in, it can also corrupt selected words on request to exercise the far-end checker.

## Interface
Parameters:
- PREAMBLE_LEN, 16: idle words sent before PRBS data; legal range 2..255.
- IDLE_WORD, 16'hBC50: word driven on tx_word whenever PRBS data is not being sent.

Ports:
- clk1280, input, 1: the single clock; every register is on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: run request; honoured only in IDLE.
- abort, input, 1: terminates a run from any non-IDLE state.
- burst_len, input, 32: number of PRBS words per run; sampled on an accepted start; 0 means continuous.
- prbs_word, input, 16: word from the PRBS generator.
- prbs_load, output, 1: one-cycle pulse that reseeds the generator.
- prbs_en, output, 1: generator advance enable.
- tx_word, output, 16: registered lane word.
- tx_valid, output, 1: high while tx_word carries preamble or PRBS data.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when a counted run completes normally.
- word_cnt, output, 32: number of PRBS words sent in the current or most recent run.
- inj_req, input, 1: error-injection request pulse (see Configuration).
- inj_mask, input, 16: XOR mask applied to the injected word.
- inj_ack, output, 1: high in the cycle the corrupted word is on tx_word.

## Operation
- FSM states and transitions:
  - IDLE -> SEED when start=1 and abort=0.
  - SEED -> PRE, always after 1 cycle.
  - PRE -> RUN after PREAMBLE_LEN cycles.
  - RUN -> DONE after burst_len words (only when burst_len != 0).
  - DONE -> IDLE after 1 cycle.
  - abort=1 in SEED, PRE, RUN or DONE -> IDLE on the next edge; done is not pulsed.
- An accepted start latches burst_len into a holding register and clears word_cnt to 0.
- start while busy is ignored. start and abort together in IDLE: stay in IDLE.
- State actions (all outputs registered):
  - SEED: prbs_load=1; tx_word=IDLE_WORD; tx_valid=0.
  - PRE: prbs_en=1; tx_word=IDLE_WORD; tx_valid=1. The preamble covers the generator's 2-cycle output pipeline, so the first RUN word is valid.
  - RUN: prbs_en=1; tx_word=prbs_word; tx_valid=1; word_cnt increments by 1 per cycle.
  - DONE: prbs_en=0; tx_word=IDLE_WORD; tx_valid=0; done=1.
  - IDLE: prbs_en=0; tx_word=IDLE_WORD; tx_valid=0.
- RUN ends when word_cnt reaches the latched burst_len.
- In continuous mode, word_cnt wraps from 32'hFFFFFFFF to 0 and RUN continues.
- word_cnt holds its value in IDLE, including after an abort, until the next accepted start.
- Reset values: state=IDLE, tx_word=IDLE_WORD, prbs_load=0, prbs_en=0, tx_valid=0, busy=0, done=0, word_cnt=0, inj_ack=0. An assertion of rst_n mid-run forces these values immediately.

## Timing
- start sampled at edge N: busy=1 and prbs_load=1 at N+1; preamble words at N+2 .. N+1+PREAMBLE_LEN; first PRBS word at N+2+PREAMBLE_LEN.
- tx_word follows prbs_word with 1 cycle of register latency.
- Counted run of B words: the last PRBS word is at N+1+PREAMBLE_LEN+B; done=1 and tx_valid=0 one cycle after it; busy=0 the cycle after done.
- abort sampled at edge M: tx_valid=0, busy=0 and prbs_en=0 at M+1.

## Configuration
- PRBS_TX_SEQ_ERR_INJ_EN defined:
  - A rising inj_req sets a pending flag; the flag is cleared on entry to IDLE.
  - The next RUN word after the flag is set goes out as prbs_word ^ inj_mask, with inj_ack=1 in that same cycle; the flag then clears.
  - Requests made outside RUN stay pending until RUN.
  - A request while one is already pending is merged into the pending one.
- PRBS_TX_SEQ_ERR_INJ_EN undefined:
  - inj_req and inj_mask are ignored; inj_ack is tied to 0.
  - tx_word is never modified.

## Test plan
- Reset, then hold rst_n=0: tx_word=16'hBC50, busy=0, word_cnt=0, all strobes 0.
- start with burst_len=100, PREAMBLE_LEN=16 -> one prbs_load pulse; 16 tx_valid idle words; 100 words matching the generator model; done pulse one cycle after the 100th word; word_cnt=100.
- burst_len=0 with word_cnt forced near 32'hFFFFFFFF -> word_cnt wraps to 0, RUN continues; abort -> tx_valid=0 the next cycle, no done pulse.
- start pulsed during RUN, and start+abort together in IDLE -> neither starts a run; burst_len changed mid-run has no effect.
- rst_n asserted mid-RUN -> all outputs return to reset values asynchronously; the next start runs normally.
- With PRBS_TX_SEQ_ERR_INJ_EN: inj_req during PRE, inj_mask=16'h0001 -> first RUN word has bit 0 flipped, with inj_ack at that same cycle; without the macro, every word matches the model and inj_ack stays 0.

Source files
------------

// File: rtl/prbs_tx_seq.sv
// Run sequencer for the PRBS transmit lane: reseed, idle preamble, counted or continuous burst.
// Define PRBS_TX_SEQ_ERR_INJ_EN to compile in on-request word corruption for far-end checker tests.
module prbs_tx_seq #(
  parameter int unsigned PREAMBLE_LEN = 16,
  parameter logic [15:0] IDLE_WORD    = 16'hBC50
) (
  input  logic        clk1280,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] burst_len,
  input  logic [15:0] prbs_word,
  output logic        prbs_load,
  output logic        prbs_en,
  output logic [15:0] tx_word,
  output logic        tx_valid,
  output logic        busy,
  output logic        done,
  output logic [31:0] word_cnt,
  input  logic        inj_req,
  input  logic [15:0] inj_mask,
  output logic        inj_ack
);

  typedef enum logic [2:0] {S_IDLE, S_SEED, S_PRE, S_RUN, S_DONE} state_t;

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);

  state_t      state_q, state_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic [31:0] burst_q, burst_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [15:0] tx_word_d;
  logic [15:0] inj_xor;
  logic        inj_ack_d;

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    burst_d    = burst_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_SEED;
          burst_d    = burst_len;
          word_cnt_d = '0;
        end
      end
      S_SEED: begin
        state_d   = S_PRE;
        pre_cnt_d = '0;
      end
      S_PRE: begin
        if (pre_cnt_q == PRE_LAST) state_d = S_RUN;
        else                       pre_cnt_d = pre_cnt_q + 8'd1;
      end
      S_RUN: begin
        // a zero burst length never completes: continuous streaming
        if ((burst_q != '0) && (word_cnt_q == burst_q)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
    if (state_d == S_RUN) word_cnt_d = word_cnt_q + 32'd1;
  end

`ifdef PRBS_TX_SEQ_ERR_INJ_EN
  logic inj_req_q, pend_q, pend_d, inj_fire;

  always_comb begin
    inj_fire = pend_q && (state_d == S_RUN);
    pend_d   = pend_q;
    if (inj_fire) pend_d = 1'b0;
    if ((state_d == S_IDLE) && (state_q != S_IDLE)) pend_d = 1'b0;
    // a fresh request merges into any pending one
    if (inj_req && !inj_req_q) pend_d = 1'b1;
  end

  assign inj_xor   = inj_fire ? inj_mask : 16'h0000;
  assign inj_ack_d = inj_fire;

  always_ff @(posedge clk1280 or negedge rst_n) begin
    if (!rst_n) begin
      inj_req_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      inj_req_q <= inj_req;
      pend_q    <= pend_d;
    end
  end
`else
  logic unused_inj;
  assign unused_inj = ^{inj_req, inj_mask};
  assign inj_xor    = 16'h0000;
  assign inj_ack_d  = 1'b0;
`endif

  always_comb begin
    tx_word_d = IDLE_WORD;
    if (state_d == S_RUN) tx_word_d = prbs_word ^ inj_xor;
  end

  // outputs are decoded from the next state so every strobe is a flop
  always_ff @(posedge clk1280 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      burst_q    <= '0;
      word_cnt_q <= '0;
      tx_word    <= IDLE_WORD;
      prbs_load  <= 1'b0;
      prbs_en    <= 1'b0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      inj_ack    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      burst_q    <= burst_d;
      word_cnt_q <= word_cnt_d;
      tx_word    <= tx_word_d;
      prbs_load  <= (state_d == S_SEED);
      prbs_en    <= (state_d == S_PRE) || (state_d == S_RUN);
      tx_valid   <= (state_d == S_PRE) || (state_d == S_RUN);
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_DONE);
      inj_ack    <= inj_ack_d;
    end
  end

  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_prbs_tx_seq.sv
// Bench for prbs_tx_seq: table-driven cycle vectors with a word scoreboard, plus hand-written corner sequences.
module tb_prbs_tx_seq;
  localparam int          P      = 16;
  localparam logic [15:0] IDLE_W = 16'hBC50;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [15:0] MASK   = 16'h0001;
`ifdef PRBS_TX_SEQ_ERR_INJ_EN
  localparam bit INJ_ON = 1'b1;
`else
  localparam bit INJ_ON = 1'b0;
`endif

  logic        clk1280 = 1'b0;
  logic        rst_n, start, abort, inj_req;
  logic [31:0] burst_len;
  logic [15:0] prbs_word, inj_mask;
  logic        prbs_load, prbs_en, tx_valid, busy, done, inj_ack;
  logic [15:0] tx_word;
  logic [31:0] word_cnt;

  always #5 clk1280 = ~clk1280;

  prbs_tx_seq #(.PREAMBLE_LEN(P), .IDLE_WORD(IDLE_W)) dut (
    .clk1280(clk1280), .rst_n(rst_n), .start(start), .abort(abort),
    .burst_len(burst_len), .prbs_word(prbs_word), .prbs_load(prbs_load),
    .prbs_en(prbs_en), .tx_word(tx_word), .tx_valid(tx_valid), .busy(busy),
    .done(done), .word_cnt(word_cnt), .inj_req(inj_req), .inj_mask(inj_mask),
    .inj_ack(inj_ack)
  );

  // Generator model: 16-bit LFSR, reseeded by prbs_load, advanced by prbs_en, 2-cycle output pipeline.
  logic [15:0] g_q, p1_q, p2_q;
  always @(posedge clk1280 or negedge rst_n) begin
    if (!rst_n) begin
      g_q <= SEED; p1_q <= 16'h0000; p2_q <= 16'h0000;
    end else begin
      if (prbs_load)    g_q <= SEED;
      else if (prbs_en) g_q <= {g_q[14:0], g_q[15] ^ g_q[13] ^ g_q[12] ^ g_q[10]};
      p1_q <= g_q;
      p2_q <= p1_q;
    end
  end
  assign prbs_word = p2_q;

  typedef struct {
    logic        start, abort, inj;
    logic [31:0] blen;
    logic        busy, valid, load, en, done, run, ack;
    logic [31:0] wc;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] exp_q[$];
  int          nvec = 0;
  int          nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {26'd0, busy, tx_valid, prbs_load, prbs_en, done, inj_ack};
  endfunction

  function automatic void add(input logic st, input logic ab, input logic ij, input logic [31:0] bl,
                              input logic bz, input logic vl, input logic ld, input logic en,
                              input logic dn, input logic rn, input logic ak, input logic [31:0] wc);
    vec_t v;
    v.start = st; v.abort = ab; v.inj = ij; v.blen = bl;
    v.busy = bz; v.valid = vl; v.load = ld; v.en = en; v.done = dn; v.run = rn; v.ack = ak; v.wc = wc;
    tbl.push_back(v);
  endfunction

  // Start a run of b words; a start and a burst_len change arrive mid-run and must be ignored.
  task automatic build(input logic [31:0] b, input int nrun, input bit tail, input int inj_at);
    add(1'b1, 1'b0, 1'b0, b, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < P; i++)
      add(i == 5, 1'b0, i == inj_at, (i == 5) ? 32'd7 : b,
          1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int k = 1; k <= nrun; k++)
      add(k == 2, 1'b0, 1'b0, (k == 1) ? 32'd9 : b,
          1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, INJ_ON && (inj_at >= 0) && (k == 1), 32'(k));
    if (tail) begin
      add(1'b0, 1'b0, 1'b0, b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b);
      add(1'b0, 1'b0, 1'b0, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b);
    end
  endtask

  // Called at a falling edge; each record drives inputs, then its outputs are checked one cycle later.
  task automatic apply();
    vec_t        v;
    logic [15:0] ew;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      start = v.start; abort = v.abort; inj_req = v.inj; burst_len = v.blen;
      if (v.run) exp_q.push_back(prbs_word ^ (v.ack ? MASK : 16'h0000));
      @(negedge clk1280);
      chk("ctl", ctl(), {26'd0, v.busy, v.valid, v.load, v.en, v.done, v.ack});
      ew = IDLE_W;
      if (v.run) ew = exp_q.pop_front();
      chk("tx_word", {16'd0, tx_word}, {16'd0, ew});
      chk("word_cnt", word_cnt, v.wc);
    end
    tbl.delete();
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; inj_req = 1'b0; inj_mask = MASK; burst_len = 32'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_word", {16'd0, tx_word}, {16'd0, IDLE_W});
    chk("rst_ctl", ctl(), 32'd0);
    chk("rst_word_cnt", word_cnt, 32'd0);
    @(negedge clk1280);
    chk("rst_hold_ctl", ctl(), 32'd0);
    chk("rst_hold_tx_word", {16'd0, tx_word}, {16'd0, IDLE_W});
    @(negedge clk1280);
    rst_n = 1'b1;

    // start+abort together in IDLE, then a 100-word counted run with an injection request in PRE
    add(1'b1, 1'b1, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    build(32'd100, 100, 1'b1, 3);
    apply();

    // continuous run, word_cnt pushed to the wrap point, then abort
    build(32'd0, 3, 1'b0, -1);
    apply();
    force dut.word_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.word_cnt_q;
    chk("wrap_forced", word_cnt, 32'hFFFF_FFFE);
    @(negedge clk1280);
    chk("wrap_max", word_cnt, 32'hFFFF_FFFF);
    @(negedge clk1280);
    chk("wrap_zero", word_cnt, 32'd0);
    chk("wrap_ctl", ctl(), 32'b110100);
    @(negedge clk1280);
    chk("wrap_one", word_cnt, 32'd1);
    abort = 1'b1;
    @(negedge clk1280);
    abort = 1'b0;
    chk("abort_ctl", ctl(), 32'd0);
    chk("abort_tx_word", {16'd0, tx_word}, {16'd0, IDLE_W});
    chk("abort_word_cnt", word_cnt, 32'd1);
    @(negedge clk1280);
    chk("abort_no_done", ctl(), 32'd0);
    chk("abort_hold_cnt", word_cnt, 32'd1);

    // reset asserted mid-run, then a normal short run
    build(32'd50, 10, 1'b0, -1);
    apply();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctl", ctl(), 32'd0);
    chk("midrst_tx_word", {16'd0, tx_word}, {16'd0, IDLE_W});
    chk("midrst_word_cnt", word_cnt, 32'd0);
    @(negedge clk1280);
    rst_n = 1'b1;
    build(32'd4, 4, 1'b1, -1);
    apply();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
